// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU result write-back stage.
// Holds the write-back FSM encoding and the per-lane de-skew delay rule.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wb_state_e;

    // Lane j arrives j*step late, so it is held back by the remainder.
    function automatic int lane_deskew_delay(
        input int lane,
        input int lanes,
        input int step
    );
        return (lanes - 1 - lane) * step;
    endfunction

endpackage

// File: rtl/lane_delay_line.sv
// Fixed-depth shift register used to re-align one skewed lane.
// DEPTH of zero degenerates to a plain wire.
module lane_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_reg
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/tpu_deskew_writeback.sv
// De-skews staggered VPU lanes into rows and writes a tile to the output buffer.
// Define TPU_WB_ZERO_MASKED_EN to force masked lanes of wr_data to zero.
module tpu_deskew_writeback
    import tpu_pkg::*;
#(
    parameter int LANES        = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int SKEW_STEP    = 1,
    parameter int ROWCNT_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start,
    input  logic                    cfg_abort,
    input  logic [ADDR_WIDTH-1:0]   cfg_base_addr,
    input  logic [ROWCNT_WIDTH-1:0] cfg_row_count,
    input  logic [LANES-1:0]        cfg_col_mask,
    input  logic [DATA_WIDTH-1:0]   in_data [LANES],
    input  logic                    in_valid [LANES],
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data [LANES],
    output logic                    busy,
    output logic                    done,
    output logic                    err_misalign,
    output logic [ROWCNT_WIDTH-1:0] rows_written
);

    logic [DATA_WIDTH-1:0]   al_data [LANES];
    logic [LANES-1:0]        al_valid;
    logic [LANES-1:0]        mask_q;
    logic [ROWCNT_WIDTH-1:0] count_q;

    wb_state_e state;
    wb_state_e state_nx;

    logic row_valid;
    logic row_partial;
    logic tile_full;
    logic active;
    logic do_write;
    logic do_start;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        localparam int DLY = lane_deskew_delay(j, LANES, SKEW_STEP);
        logic [DATA_WIDTH:0] q;

        lane_delay_line #(
            .DEPTH(DLY),
            .WIDTH(DATA_WIDTH + 1)
        ) u_dly (
            .clk(clk),
            .rst(rst),
            .d  ({in_valid[j], in_data[j]}),
            .q  (q)
        );

        assign al_valid[j] = q[DATA_WIDTH];
        assign al_data[j]  = q[DATA_WIDTH-1:0];
    end

    assign row_valid   = &(al_valid | ~mask_q);
    assign row_partial = (|(al_valid & mask_q)) & ~row_valid;

    // After the last write the tile spends one cycle "full" so done trails it.
    assign tile_full = (rows_written == count_q);
    assign active    = (state == RUN) && !tile_full;
    assign do_write  = active && row_valid;
    assign do_start  = (state == IDLE) && cfg_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_nx = (cfg_row_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (tile_full) begin
                    state_nx = DONE;
                end else if (cfg_abort) begin
                    state_nx = IDLE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            err_misalign <= 1'b0;
            rows_written <= '0;
            mask_q       <= '0;
            count_q      <= '0;
            for (int k = 0; k < LANES; k++) begin
                wr_data[k] <= '0;
            end
        end else begin
            wr_en <= do_write;

            if (do_start) begin
                mask_q       <= cfg_col_mask;
                count_q      <= cfg_row_count;
                wr_addr      <= cfg_base_addr;
                rows_written <= '0;
                err_misalign <= 1'b0;
            end else if (wr_en) begin
                wr_addr <= wr_addr + ADDR_WIDTH'(1);
            end

            if (do_write) begin
                rows_written <= rows_written + ROWCNT_WIDTH'(1);
                for (int k = 0; k < LANES; k++) begin
`ifdef TPU_WB_ZERO_MASKED_EN
                    wr_data[k] <= mask_q[k] ? al_data[k] : '0;
`else
                    wr_data[k] <= al_data[k];
`endif
                end
            end

            if (active && row_partial) begin
                err_misalign <= 1'b1;
            end
        end
    end

endmodule
